// File: rtl/imm_ext_pipe.sv
// RV immediate generator for the decode stage: decodes I/S/B/U/J/CSR-zimm immediates
// and queues them with a sideband tag in a 2-entry valid/ready output buffer.
module imm_ext_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      Instr,
  input  logic [2:0]       ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  ImmExt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  typedef enum logic [2:0] {
    SRC_I = 3'b000,
    SRC_S = 3'b001,
    SRC_B = 3'b010,
    SRC_U = 3'b011,
    SRC_J = 3'b100,
    SRC_Z = 3'b101
  } immSrc_e;

  logic signed [31:0] rawImm;
  logic [XLEN-1:0]    immDec;
  logic               illDec;
  logic               signBit;

  // Instr carries instruction bits [31:7], so instruction bit k sits at Instr[k-7].
  assign signBit = Instr[24];

  always_comb begin
    rawImm = '0;
    illDec = 1'b0;
    case (ImmSrc)
      SRC_I:   rawImm = {{20{signBit}}, Instr[24:13]};
      SRC_S:   rawImm = {{20{signBit}}, Instr[24:18], Instr[4:0]};
      SRC_B:   rawImm = {{20{signBit}}, Instr[0], Instr[23:18], Instr[4:1], 1'b0};
      SRC_U:   rawImm = {Instr[24:5], 12'b0};
      SRC_J:   rawImm = {{12{signBit}}, Instr[12:5], Instr[13], Instr[23:14], 1'b0};
      SRC_Z:   rawImm = {27'b0, Instr[12:8]};
      default: illDec = 1'b1;
    endcase
  end

  assign immDec = XLEN'(rawImm);

  logic [XLEN-1:0]  immQ [2];
  logic [TAG_W-1:0] tagQ [2];
  logic             illQ [2];
  logic             headQ, headD;
  logic             tailQ, tailD;
  logic [1:0]       countQ, countD;
  logic             push, pop;

  assign in_ready  = (countQ != 2'd2) || out_ready;
  assign out_valid = (countQ != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  assign headD  = headQ ^ pop;
  assign tailD  = tailQ ^ push;
  assign countD = countQ + {1'b0, push} - {1'b0, pop};

  // Head data is gated so a drained buffer never shows a stale popped entry.
  assign ImmExt      = out_valid ? immQ[headQ] : '0;
  assign out_tag     = out_valid ? tagQ[headQ] : '0;
  assign out_illegal = out_valid && illQ[headQ];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      headQ  <= 1'b0;
      tailQ  <= 1'b0;
      countQ <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        immQ[i] <= '0;
        tagQ[i] <= '0;
        illQ[i] <= 1'b0;
      end
    end else begin
      headQ  <= headD;
      tailQ  <= tailD;
      countQ <= countD;
      if (push) begin
        immQ[tailQ] <= immDec;
        tagQ[tailQ] <= in_tag;
        illQ[tailQ] <= illDec;
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Drives 32- and 64-bit instances of imm_ext_pipe with shared stimulus and compares both
// against an arithmetic immediate model feeding a queue-based buffer model.
module tb_imm_ext_pipe;

  localparam int TAG_W = 5;
  localparam logic [2:0] FMT_I = 3'd0, FMT_S = 3'd1, FMT_B = 3'd2, FMT_U = 3'd3,
                         FMT_J = 3'd4, FMT_Z = 3'd5, FMT_X = 3'd7;

  logic             clk = 1'b0;
  logic             reset, flush, inValid, outReady;
  logic [31:0]      instrWord;
  logic [2:0]       immSrc;
  logic [TAG_W-1:0] inTag;

  logic             inReady32, outValid32, outIllegal32;
  logic [31:0]      immExt32;
  logic [TAG_W-1:0] outTag32;
  logic             inReady64, outValid64, outIllegal64;
  logic [63:0]      immExt64;
  logic [TAG_W-1:0] outTag64;

  int passCount  = 0;
  int totalCount = 0;

  typedef struct {
    logic [63:0]      imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } entry_t;

  entry_t modelQ[$];

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(inReady32),
    .Instr(instrWord[31:7]), .ImmSrc(immSrc), .in_tag(inTag), .out_valid(outValid32),
    .out_ready(outReady), .ImmExt(immExt32), .out_tag(outTag32), .out_illegal(outIllegal32)
  );

  imm_ext_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(inValid), .in_ready(inReady64),
    .Instr(instrWord[31:7]), .ImmSrc(immSrc), .in_tag(inTag), .out_valid(outValid64),
    .out_ready(outReady), .ImmExt(immExt64), .out_tag(outTag64), .out_illegal(outIllegal64)
  );

  // Immediate value computed from the whole instruction word with shifts and masks.
  function automatic logic [63:0] refImm(input logic [31:0] w, input logic [2:0] src);
    longint      s, sh;
    logic [63:0] uw;
    s  = $signed(w);
    uw = {32'b0, w};
    case (src)
      FMT_I: begin sh = s >>> 20; return sh; end
      FMT_S: begin sh = s >>> 25; return (sh << 5) | ((uw >> 7) & 64'h1F); end
      FMT_B: begin
        sh = s >>> 31;
        return (sh << 12) | (((uw >> 7) & 64'h1) << 11) |
               (((uw >> 25) & 64'h3F) << 5) | (((uw >> 8) & 64'hF) << 1);
      end
      FMT_U: return s & ~64'hFFF;
      FMT_J: begin
        sh = s >>> 31;
        return (sh << 20) | (((uw >> 12) & 64'hFF) << 12) |
               (((uw >> 20) & 64'h1) << 11) | (((uw >> 21) & 64'h3FF) << 1);
      end
      FMT_Z: return (uw >> 15) & 64'h1F;
      default: return 64'h0;
    endcase
  endfunction

  task automatic checkVal(input string name, input logic [63:0] obs, input logic [63:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  // Compares every head-side output of both instances with the buffer model.
  task automatic checkOutput();
    entry_t head;
    logic   expValid;
    expValid = (modelQ.size() != 0);
    head = '{imm: 64'h0, tag: '0, ill: 1'b0};
    if (expValid) head = modelQ[0];
    checkVal("out_valid32", {63'b0, outValid32}, {63'b0, expValid});
    checkVal("out_valid64", {63'b0, outValid64}, {63'b0, expValid});
    checkVal("ImmExt32", {32'b0, immExt32}, {32'b0, head.imm[31:0]});
    checkVal("ImmExt64", immExt64, head.imm);
    checkVal("out_tag32", {59'b0, outTag32}, {59'b0, head.tag});
    checkVal("out_tag64", {59'b0, outTag64}, {59'b0, head.tag});
    checkVal("out_illegal32", {63'b0, outIllegal32}, {63'b0, head.ill});
    checkVal("out_illegal64", {63'b0, outIllegal64}, {63'b0, head.ill});
  endtask

  // One clock cycle: check the current state, drive inputs, then advance the model.
  task automatic applyStimulus(input bit r, input bit fl, input bit v, input logic [31:0] w,
                               input logic [2:0] src, input logic [TAG_W-1:0] tag,
                               input bit ordy);
    bit modelReady;
    @(negedge clk);
    checkOutput();
    reset = r; flush = fl; inValid = v; instrWord = w; immSrc = src; inTag = tag;
    outReady = ordy;
    #1;
    modelReady = (modelQ.size() < 2) || ordy;
    checkVal("in_ready32", {63'b0, inReady32}, {63'b0, modelReady});
    checkVal("in_ready64", {63'b0, inReady64}, {63'b0, modelReady});
    if (r || fl) begin
      modelQ.delete();
    end else begin
      if (modelQ.size() != 0 && ordy) void'(modelQ.pop_front());
      if (v && modelReady)
        modelQ.push_back('{imm: refImm(w, src), tag: tag, ill: (src > FMT_Z)});
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; inValid = 1'b0; outReady = 1'b0;
    instrWord = '0; immSrc = '0; inTag = '0;
    repeat (2) @(posedge clk);

    // Single pushes into an empty buffer with the consumer always ready.
    applyStimulus(0, 0, 1, 32'hFFF00093, FMT_I, 5'd1, 1);
    applyStimulus(0, 0, 1, 32'hFE000EE3, FMT_B, 5'd2, 1);
    applyStimulus(0, 0, 1, 32'h008000EF, FMT_J, 5'd3, 1);
    applyStimulus(0, 0, 1, 32'hFE112E23, FMT_S, 5'd4, 1);
    applyStimulus(0, 0, 1, 32'h123450B7, FMT_U, 5'd5, 1);
    applyStimulus(0, 0, 1, 32'h800000B7, FMT_U, 5'd6, 1);
    applyStimulus(0, 0, 1, 32'h000F8073, FMT_Z, 5'd7, 1);
    applyStimulus(0, 0, 1, 32'hDEADBEEF, FMT_X, 5'd8, 1);
    applyStimulus(0, 0, 1, 32'h12345678, 3'd6,  5'd9, 1);
    applyStimulus(0, 0, 0, 32'h0, FMT_I, 5'd0, 1);

    // Backpressure: the third push is held upstream until the consumer is ready.
    applyStimulus(0, 0, 1, 32'h00100093, FMT_I, 5'd1, 0);
    applyStimulus(0, 0, 1, 32'h80000FEF, FMT_J, 5'd2, 0);
    applyStimulus(0, 0, 1, 32'hFFFFF0B7, FMT_U, 5'd3, 0);
    applyStimulus(0, 0, 1, 32'hFFFFF0B7, FMT_U, 5'd3, 0);
    applyStimulus(0, 0, 1, 32'hFFFFF0B7, FMT_U, 5'd3, 1);
    applyStimulus(0, 0, 1, 32'h7FF00013, FMT_I, 5'd4, 1);
    applyStimulus(0, 0, 1, 32'h81F08A63, FMT_B, 5'd5, 1);
    applyStimulus(0, 0, 0, 32'h0, FMT_I, 5'd0, 1);
    applyStimulus(0, 0, 0, 32'h0, FMT_I, 5'd0, 1);
    applyStimulus(0, 0, 0, 32'h0, FMT_I, 5'd0, 1);

    // Flush a full buffer while a new input is also offered.
    applyStimulus(0, 0, 1, 32'h00A00093, FMT_I, 5'd10, 0);
    applyStimulus(0, 0, 1, 32'h00B00093, FMT_I, 5'd11, 0);
    applyStimulus(0, 1, 1, 32'h00C00093, FMT_I, 5'd12, 1);
    applyStimulus(0, 0, 0, 32'h0, FMT_I, 5'd0, 1);

    // Reset a full buffer, then check single-cycle latency afterwards.
    applyStimulus(0, 0, 1, 32'hFE112E23, FMT_S, 5'd13, 0);
    applyStimulus(0, 0, 1, 32'h008000EF, FMT_J, 5'd14, 0);
    applyStimulus(1, 1, 1, 32'hFFF00093, FMT_I, 5'd15, 1);
    applyStimulus(0, 0, 1, 32'h000F8073, FMT_Z, 5'd16, 1);
    applyStimulus(0, 0, 0, 32'h0, FMT_I, 5'd0, 1);

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
                    TAG_W'($urandom), ($urandom_range(0, 2) != 0));
    end

    @(negedge clk);
    checkOutput();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Pipelined, parametrised immediate generator for the RV decode stage. Covers all RV32I/RV64I immediate formats (I, S, B, U, J) plus the CSR zero-extended immediate, at width XLEN.
- Registered output behind a valid/ready handshake, with a 2-entry output buffer so upstream fetch/decode can stall without losing an instruction.
- Supports pipeline flush and flags illegal format selects.

Parameters:
- XLEN, 32, output immediate width; only 32 and 64 are legal.
- TAG_W, 5, width of the sideband tag (e.g. destination register or ROB index) carried alongside each immediate.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  discard all buffered entries and any same-cycle input
- in_valid  input  1  Instr, ImmSrc and in_tag are valid
- in_ready  output  1  block can accept an input this cycle
- Instr  input  25  instruction bits [31:7]
- ImmSrc  input  3  format select (encoding below)
- in_tag  input  TAG_W  sideband passed through unchanged
- out_valid  output  1  head entry is valid
- out_ready  input  1  consumer accepts the head entry
- ImmExt  output  XLEN  extended immediate of the head entry
- out_tag  output  TAG_W  tag of the head entry
- out_illegal  output  1  head entry had an illegal ImmSrc

Behaviour:
- Clock and reset are decided: one clock, clk; reset is synchronous and active-high, named reset.
- Format decode (combinational, at input). "sx" means sign-extend from Instr[31] to XLEN:
  - 000 I: sx{Instr[31:20]}
  - 001 S: sx{Instr[31:25], Instr[11:7]}
  - 010 B: sx{Instr[7], Instr[30:25], Instr[11:8], 1'b0}
  - 011 U: sx{Instr[31:12], 12'b0}. For XLEN=64, bit 31 sign-extends into [63:32].
  - 100 J: sx{Instr[19:12], Instr[20], Instr[30:21], 1'b0}
  - 101 Z (CSR zimm): zero-extend Instr[19:15]
  - 110/111: ImmExt=0, illegal=1. Never X.
- Buffer:
  - 2-entry FIFO of {ImmExt, tag, illegal}, with head pointer, tail pointer and a 2-bit count (0..2).
  - Pointers wrap modulo 2.
- Handshake rules:
  - in_ready = (count<2) || out_ready. Accept when in_valid && in_ready && !flush.
  - Pop when out_valid && out_ready.
  - out_valid = (count!=0). ImmExt, out_tag and out_illegal come from the head entry. Head data must remain stable while out_valid && !out_ready.
- Latency: an accepted input appears on the outputs the next cycle when the buffer was empty. Otherwise it appears after the earlier entries drain. Ordering is strictly FIFO.
- Throughput: 1 entry/cycle sustained with out_ready=1.
- Boundary cases:
  - Push and pop in the same cycle with count=2: allowed, count stays 2.
  - Push and pop in the same cycle with count=1: count stays 1.
  - Pop with count=0: impossible, since out_valid=0.
  - in_valid while full and !out_ready: in_ready=0. Input is not captured; upstream must hold it.
- Flush:
  - Next cycle: count=0, pointers=0, out_valid=0.
  - Flush has priority over a same-cycle push and pop; the input is dropped.
  - in_ready is unaffected by flush.
- Reset:
  - count=0, head=tail=0, out_valid=0, ImmExt=0, out_tag=0, out_illegal=0.
  - Asserting reset mid-operation discards all entries at the next clock edge.
  - Reset dominates flush.
- Output data when out_valid=0: 0 (storage is cleared on reset and flush).
- Illegal entries flow through the FIFO like any other entry; they are not dropped.

Test Plan:
- XLEN=32, empty buffer, out_ready=1:
  - push I 0xFFF00093 -> next cycle out_valid=1, ImmExt=0xFFFFFFFF
  - push B 0xFE000EE3 -> ImmExt=0xFFFFFFFC
  - push J 0x008000EF -> ImmExt=0x00000008
  - push S 0xFE112E23 -> ImmExt=0xFFFFFFFC
- U and Z formats:
  - XLEN=32, U 0x123450B7 -> 0x12345000
  - XLEN=64, U 0x800000B7 -> 0xFFFFFFFF80000000
  - Z with Instr[19:15]=11111 -> 0x1F (no sign extension)
- Backpressure: out_ready=0, push tags 1,2,3 back-to-back:
  - in_ready drops after 2 accepts; tag 3 is held upstream
  - raise out_ready -> tags emerge 1,2,3 on consecutive cycles with correct immediates
- Simultaneous push/pop at count=2 with out_ready=1 -> count stays 2, no entry lost or duplicated, order preserved.
- Illegal and flush:
  - ImmSrc=111 -> out_illegal=1, ImmExt=0
  - flush with count=2 plus in_valid in the same cycle -> next cycle out_valid=0; the flushed input never appears
- Reset asserted with count=2 -> next cycle all outputs 0, out_valid=0; the first push after reset emerges with 1-cycle latency.
